// File: rtl/max_pool_stream_if.sv
// Stream bundle between the conv output buffer, the 2x2 max-pool stage and its consumer.
// The slave modport is the pooling block's view.
interface max_pool_stream_if #(
    parameter int BitSize = 32
);
    logic               in_valid;
    logic [BitSize-1:0] in_data;
    logic               image_done;
    logic               pooling_done;
    logic               out_valid;
    logic [BitSize-1:0] out_data;
    logic               out_last;
    logic               err;

    modport master (
        output in_valid, in_data, image_done,
        input  pooling_done, out_valid, out_data, out_last, err
    );

    modport slave (
        input  in_valid, in_data, image_done,
        output pooling_done, out_valid, out_data, out_last, err
    );
endinterface

// File: rtl/max_pool_stream.sv
// Streaming 2x2/stride-2 max pooling over raster-ordered feature maps, one map at a time.
// Even rows fold column pairs into a line buffer; odd rows finish each window and emit it.
module max_pool_stream #(
    parameter int BitSize    = 32,
    parameter int ImageWidth = 4,
    parameter int NumberOfK  = 4,
    parameter int IsSigned   = 0
) (
    input logic              clk,
    input logic              res,
    max_pool_stream_if.slave bus
);
    localparam int CW = (ImageWidth > 2) ? $clog2(ImageWidth) : 1;
    localparam int HW = ImageWidth / 2;
    localparam int IW = (HW > 1) ? $clog2(HW) : 1;
    localparam int KW = (NumberOfK > 1) ? $clog2(NumberOfK) : 1;
    localparam logic [CW-1:0] COL_LAST  = CW'(ImageWidth - 1);
    localparam logic [KW-1:0] KERN_LAST = KW'(NumberOfK - 1);

    typedef enum logic [1:0] {
        ST_TOP    = 2'd0,
        ST_BOTTOM = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      col_q, col_d;
    logic [CW-1:0]      row_q, row_d;
    logic [KW-1:0]      kern_q, kern_d;
    logic [BitSize-1:0] hold_q, hold_d;
    logic [BitSize-1:0] lbuf_q [HW];
    logic [BitSize-1:0] lbuf_d [HW];
    logic               out_valid_q, out_valid_d;
    logic [BitSize-1:0] out_data_q, out_data_d;
    logic               out_last_q, out_last_d;
    logic               pooling_done_q, pooling_done_d;
    logic               err_q, err_d;

    logic               accept;
    logic               row_end;
    logic [IW-1:0]      bidx;

    function automatic logic [BitSize-1:0] max_of(input logic [BitSize-1:0] a,
                                                  input logic [BitSize-1:0] b);
        logic signed [BitSize-1:0] sa;
        logic signed [BitSize-1:0] sb;
        sa = a;
        sb = b;
        if (IsSigned != 0) return (sa >= sb) ? a : b;
        return (a >= b) ? a : b;
    endfunction

    // A pixel offered while the map is being closed out is never consumed.
    assign accept  = bus.in_valid && (state_q != ST_DONE);
    assign row_end = (col_q == COL_LAST);
    assign bidx    = IW'(col_q >> 1);

    always_comb begin
        state_d        = state_q;
        col_d          = col_q;
        row_d          = row_q;
        kern_d         = kern_q;
        hold_d         = hold_q;
        lbuf_d         = lbuf_q;
        out_valid_d    = 1'b0;
        out_data_d     = out_data_q;
        out_last_d     = 1'b0;
        pooling_done_d = 1'b0;
        err_d          = err_q;

        if (bus.in_valid && (state_q == ST_DONE)) err_d = 1'b1;
        if (bus.image_done && (state_q != ST_DONE) && ((row_q != '0) || (col_q != '0))) err_d = 1'b1;

        if (accept) begin
            col_d = row_end ? '0 : col_q + 1'b1;
            if (row_end) row_d = (row_q == COL_LAST) ? '0 : row_q + 1'b1;
        end

        case (state_q)
            ST_TOP: begin
                if (accept) begin
                    if (!col_q[0]) hold_d = bus.in_data;
                    else           lbuf_d[bidx] = max_of(hold_q, bus.in_data);
                    if (row_end) state_d = ST_BOTTOM;
                end
            end
            ST_BOTTOM: begin
                if (accept) begin
                    if (!col_q[0]) begin
                        hold_d = max_of(lbuf_q[bidx], bus.in_data);
                    end else begin
                        out_valid_d = 1'b1;
                        out_data_d  = max_of(hold_q, bus.in_data);
                        out_last_d  = (kern_q == KERN_LAST) && (row_q == COL_LAST) && row_end;
                    end
                    if (row_end) state_d = (row_q == COL_LAST) ? ST_DONE : ST_TOP;
                end
            end
            ST_DONE: begin
                pooling_done_d = 1'b1;
                col_d          = '0;
                row_d          = '0;
                kern_d         = (kern_q == KERN_LAST) ? '0 : kern_q + 1'b1;
                state_d        = ST_TOP;
            end
            default: state_d = ST_TOP;
        endcase
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q        <= ST_TOP;
            col_q          <= '0;
            row_q          <= '0;
            kern_q         <= '0;
            hold_q         <= '0;
            lbuf_q         <= '{default: '0};
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
            out_last_q     <= 1'b0;
            pooling_done_q <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            col_q          <= col_d;
            row_q          <= row_d;
            kern_q         <= kern_d;
            hold_q         <= hold_d;
            lbuf_q         <= lbuf_d;
            out_valid_q    <= out_valid_d;
            out_data_q     <= out_data_d;
            out_last_q     <= out_last_d;
            pooling_done_q <= pooling_done_d;
            err_q          <= err_d;
        end
    end

    assign bus.out_valid    = out_valid_q;
    assign bus.out_data     = out_data_q;
    assign bus.out_last     = out_last_q;
    assign bus.pooling_done = pooling_done_q;
    assign bus.err          = err_q;
endmodule
